npu_feeder: RTL
===============

# npu_feeder

Synthesizable host-side sequencer for the NPU's shared 32-bit `we`/`oe` data bus. It replaces the fixed-delay stimulus flow with a handshaked one: it accepts a word stream, sends it to the NPU as configuration, weights and inputs, waits on `ready` with a timeout, and streams results out with backpressure. Compared with the previous flow, it adds a weight-reuse mode that skips reloading config and weights, plus parametrised widths and depths. It sits between a DMA/host stream and the `npu` top.

## Interface
- `DW`, 32: bus and data word width.
- `WCNT_W`, 12: width of the weight-count field; max weights 2^WCNT_W−1.
- `IO_W`, 5: width of in/out neuron-count fields (stored as count−1).
- `TMO`, 1024: cycles to wait for `npu_ready` before flagging an error.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  one-cycle pulse that begins a job; ignored unless `busy`=0.
- `keep_w`  in  1  sampled with `start`; 1 skips the CFG and WGT phases and reuses the last config.
- `num_w`  in  WCNT_W  number of weight+bias words; sampled with `start`.
- `src_valid` / `src_ready` / `src_data`  in/out/in  1/1/DW  input word stream.
- `res_valid` / `res_ready` / `res_data` / `res_last`  out/in/out/out  1/1/DW/1  result stream; `res_last` marks the final output.
- `npu_we`, `npu_oe`  out  1  NPU write and output enables.
- `npu_dout`  out  DW  value driven onto the NPU bus.
- `npu_drive`  out  1  tristate enable for `npu_dout`.
- `npu_din`  in  DW  NPU bus read-back.
- `npu_ready`  in  1  NPU computation done.
- `busy`, `err_tmo`  out  1  job in progress; sticky timeout flag, cleared by `start`.

## Operation
- States: IDLE, CFG, WGT, INP, REL, WAIT, READ, ERR.
- IDLE: `src_ready`=0. On `start`:
  - captures `num_w`;
  - goes to CFG, or to INP if `keep_w`=1 and a config is stored;
  - `keep_w`=1 with no stored config is treated as `keep_w`=0.
- CFG: accepts 6 words in this order: layers, in−1, h1, h2, out−1, act. Word 1 is latched as `n_in`, word 4 as `n_out` (low IO_W bits). Then goes to WGT.
- WGT: accepts `num_w` words. `num_w`=0 goes straight to INP.
- INP: accepts `n_in`+1 words.
- Every accepted word (`src_valid`&&`src_ready`) is forwarded in the same cycle: `npu_we`=1, `npu_drive`=1, `npu_dout`=`src_data`.
- A cycle with no accepted word in CFG/WGT/INP drives `npu_we`=0. The NPU samples only when `we`=1.
- `src_ready`=1 throughout CFG, WGT and INP.
- REL: one cycle with `npu_we`=0 and `npu_drive`=0 (bus turnaround), then WAIT.
- WAIT: a counter increments each cycle. `npu_ready`=1 goes to READ. Counter reaching TMO−1 sets `err_tmo` and goes to ERR.
- READ: `npu_oe`=1 whenever the result register is empty or being consumed that cycle. Each `oe` cycle captures `npu_din` into the result register. After `n_out`+1 captures, returns to IDLE once the last result is consumed. `res_last` is asserted with the final result.
- ERR: deasserts all NPU controls and returns to IDLE; `busy` drops.
- `busy`=1 in every state except IDLE.
- A `start` pulse while `busy`=1 is ignored.
- Word counters are WCNT_W bits wide and compared for equality against the limit; they never wrap.

## Timing
- Reset values:
  - `src_ready`, `res_valid`, `res_last`, `npu_we`, `npu_oe`, `npu_drive`, `busy`, `err_tmo` = 0;
  - `npu_dout`, `res_data` = 0;
  - stored-config flag = 0; state = IDLE.
- Reset asserted mid-job: all outputs return to reset values immediately (asynchronous), and the NPU bus is released.
- `start` at edge k: `busy` goes high after edge k, and the first word can be accepted in cycle k+1.
- Input to bus: zero latency, combinational from `src_valid`.
- Bus read-back: `npu_din` is valid during an `oe` cycle and is registered at that cycle's end, so `res_valid` rises one cycle later.
- Back-to-back reads: with `res_ready`=1 held, one result per cycle.
- `npu_ready` seen at edge t: the first `oe` cycle is t+1.
- `res_valid` stays high until `res_ready`. `res_data` and `res_last` are stable while stalled.

## Structure
- Shared package `npu_pkg`: the state enum, the CFG word count (6), and the CFG word indices for in−1 and out−1.
- Single module. The result register and skid logic are inline.
- No sub-module is needed. An optional `npu_feeder_tmo` counter may be factored out if it is reused elsewhere.

## Test plan
- Basic job: 6 CFG words (0, 25, 0, 0, 0, 0), `num_w`=27, 26 inputs, `npu_ready` after 5 cycles → exactly 59 `npu_we` cycles with matching data, 1 `oe` cycle, and one result with `res_last`=1.
- `keep_w`=1 on the second job → only 26 `we` cycles, no CFG/WGT words consumed, and the same `n_out` is used.
- Random `src_valid` gaps and `res_ready` stalls (50%), `n_out`=3 → `we` cycles equal accepted words, 4 results in order, and `oe` pauses while `res_valid`&&!`res_ready`.
- `npu_ready` never rises, TMO=1024 → `err_tmo`=1 at cycle 1024 of WAIT, `busy`=0 the following cycle, and a new `start` clears `err_tmo`.
- `rst`=0 during WGT word 10 → immediate bus release and all outputs at 0; a following `keep_w`=1 job runs full CFG because the stored config was cleared.
- `start` pulsed while `busy` and `num_w`=0 → the extra `start` is ignored, and the job goes CFG→INP directly.

Source files
------------

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared constants for the NPU host-side feeder
package npu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_CFG  = 3'd1;
  localparam state_t S_WGT  = 3'd2;
  localparam state_t S_INP  = 3'd3;
  localparam state_t S_REL  = 3'd4;
  localparam state_t S_WAIT = 3'd5;
  localparam state_t S_READ = 3'd6;
  localparam state_t S_ERR  = 3'd7;

  // Configuration header: layers, in-1, h1, h2, out-1, act
  localparam int CFG_WORDS   = 6;
  localparam int CFG_IDX_IN  = 1;
  localparam int CFG_IDX_OUT = 4;

endpackage

// File: rtl/npu_feeder.sv
// rtl/npu_feeder.sv - handshaked sequencer driving the NPU we/oe bus
import npu_pkg::*;

module npu_feeder #(
  parameter int DW     = 32,
  parameter int WCNT_W = 12,
  parameter int IO_W   = 5,
  parameter int TMO    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keep_w,
  input  logic [WCNT_W-1:0] num_w,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DW-1:0]     src_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DW-1:0]     res_data,
  output logic              res_last,
  output logic              npu_we,
  output logic              npu_oe,
  output logic [DW-1:0]     npu_dout,
  output logic              npu_drive,
  input  logic [DW-1:0]     npu_din,
  input  logic              npu_ready,
  output logic              busy,
  output logic              err_tmo
);

  localparam int TW = $clog2(TMO + 1);

  state_t            state;
  logic [WCNT_W-1:0] cnt;
  logic [WCNT_W-1:0] num_w_q;
  logic [IO_W-1:0]   n_in;
  logic [IO_W-1:0]   n_out;
  logic [IO_W:0]     rd_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              cfg_ok;
  logic              accept;
  logic              rd_more;

  assign src_ready = (state == S_CFG) || (state == S_WGT) || (state == S_INP);
  assign accept    = src_valid && src_ready;
  assign npu_we    = accept;
  assign npu_drive = accept;
  assign npu_dout  = accept ? src_data : '0;
  assign busy      = (state != S_IDLE);

  // A new bus read is only issued when the result register can take it
  assign rd_more = (rd_cnt != ({1'b0, n_out} + 1'b1));
  assign npu_oe  = (state == S_READ) && rd_more && (!res_valid || res_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      num_w_q   <= '0;
      n_in      <= '0;
      n_out     <= '0;
      rd_cnt    <= '0;
      tmo_cnt   <= '0;
      cfg_ok    <= 1'b0;
      err_tmo   <= 1'b0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_data  <= '0;
    end else begin
      if (npu_oe) begin
        res_data  <= npu_din;
        res_valid <= 1'b1;
        res_last  <= (rd_cnt == {1'b0, n_out});
        rd_cnt    <= rd_cnt + 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            num_w_q <= num_w;
            err_tmo <= 1'b0;
            cnt     <= '0;
            if (keep_w && cfg_ok) begin
              state <= S_INP;
            end else begin
              cfg_ok <= 1'b0;
              state  <= S_CFG;
            end
          end
        end
        S_CFG: begin
          if (accept) begin
            if (cnt == WCNT_W'(CFG_IDX_IN))  n_in  <= src_data[IO_W-1:0];
            if (cnt == WCNT_W'(CFG_IDX_OUT)) n_out <= src_data[IO_W-1:0];
            if (cnt == WCNT_W'(CFG_WORDS - 1)) begin
              cnt    <= '0;
              cfg_ok <= 1'b1;
              state  <= (num_w_q == '0) ? S_INP : S_WGT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WGT: begin
          if (accept) begin
            if ((cnt + 1'b1) == num_w_q) begin
              cnt   <= '0;
              state <= S_INP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_INP: begin
          if (accept) begin
            if (cnt == WCNT_W'(n_in)) begin
              cnt   <= '0;
              state <= S_REL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_REL: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (npu_ready) begin
            rd_cnt <= '0;
            state  <= S_READ;
          end else if (tmo_cnt == TW'(TMO - 1)) begin
            err_tmo <= 1'b1;
            state   <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (res_valid && res_ready && res_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
